// File: rtl/multi_key_debouncer_if.sv
// Key-pad bundle between the button pins and the debouncer: raw key inputs in,
// debounced level and per-key event pulses out.
interface multi_key_debouncer_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] din;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] repeat_pulse;

    modport master (
        output din,
        input  key_state,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  din,
        output key_state,
        output press_pulse,
        output release_pulse,
        output repeat_pulse
    );
endinterface

// File: rtl/multi_key_debouncer.sv
// N independent key channels: 2-flop synchroniser, debounce FSM, press/release
// events and optional auto-repeat while held. All outputs registered.
//
// state       | meaning
// IDLE        | key released and stable
// PRESS_DEB   | press seen, waiting for it to persist
// HELD        | key accepted as pressed, repeat timer running
// RELEASE_DEB | release seen, waiting for it to persist
module multi_key_debouncer #(
    parameter int N_KEYS        = 4,
    parameter int DEBOUNCE_TIME = 10_000_000,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int ACTIVE_LOW    = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    multi_key_debouncer_if.slave  bus
);

    localparam int MAX_DR = (DEBOUNCE_TIME > REPEAT_DELAY) ? DEBOUNCE_TIME : REPEAT_DELAY;
    localparam int MAX_T  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W  = $clog2(MAX_T) + 1;

    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_TIME - 1);
    localparam logic [CNT_W-1:0] DLY_LIM = (REPEAT_DELAY > 0) ? CNT_W'(REPEAT_DELAY - 1) : '0;
    localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PERIOD - 1);
    localparam bit               RPT_EN  = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } state_t;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        logic             din_norm;
        logic             sync1_q, sync2_q;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] rpt_lim;
        logic             rpt_flag_q, rpt_flag_d;
        logic             key_q, key_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             repeat_q, repeat_d;

        assign din_norm = (ACTIVE_LOW != 0) ? ~bus.din[gi] : bus.din[gi];
        // first repeat waits the long delay, later ones use the period
        assign rpt_lim  = rpt_flag_q ? PER_LIM : DLY_LIM;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                state_q    <= IDLE;
                cnt_q      <= '0;
                rpt_flag_q <= 1'b0;
                key_q      <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                repeat_q   <= 1'b0;
            end else begin
                sync1_q    <= din_norm;
                sync2_q    <= sync1_q;
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                rpt_flag_q <= rpt_flag_d;
                key_q      <= key_d;
                press_q    <= press_d;
                release_q  <= release_d;
                repeat_q   <= repeat_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            rpt_flag_d = rpt_flag_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            repeat_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (sync2_q) state_d = PRESS_DEB;
                end
                PRESS_DEB: begin
                    if (!sync2_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LIM) begin
                        state_d    = HELD;
                        cnt_d      = '0;
                        rpt_flag_d = 1'b0;
                        press_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync2_q) begin
                        state_d = RELEASE_DEB;
                        cnt_d   = '0;
                    end else if (RPT_EN && (cnt_q == rpt_lim)) begin
                        repeat_d   = 1'b1;
                        cnt_d      = '0;
                        rpt_flag_d = 1'b1;
                    end else if (RPT_EN) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE_DEB: begin
                    // a bounce back to pressed restarts repeat timing from scratch
                    if (sync2_q) begin
                        state_d    = HELD;
                        cnt_d      = '0;
                        rpt_flag_d = 1'b0;
                    end else if (cnt_q == DEB_LIM) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            key_d = (state_d == HELD) || (state_d == RELEASE_DEB);
        end

        assign bus.key_state[gi]     = key_q;
        assign bus.press_pulse[gi]   = press_q;
        assign bus.release_pulse[gi] = release_q;
        assign bus.repeat_pulse[gi]  = repeat_q;
    end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed and random stimulus for multi_key_debouncer, checked every cycle
// against a run-length / elapsed-time model of each key.
module tb_multi_key_debouncer;
    localparam int NK = 4;
    localparam int DT = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    multi_key_debouncer_if #(.N_KEYS(NK)) bus ();

    multi_key_debouncer #(
        .N_KEYS(NK), .DEBOUNCE_TIME(DT), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // model: two-sample delay, then count consecutive samples disagreeing with
    // the accepted level; track time spent held for repeat ticks
    bit m_s1[NK], m_s2[NK], m_lvl[NK], m_first[NK];
    int m_run[NK], m_age[NK];
    logic [NK-1:0] e_key, e_press, e_rel, e_rpt;

    int ecnt;
    int press_e[NK], rel_e[NK];
    int rep_q[NK][$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NK; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_first[c] = 1;
            m_run[c] = 0; m_age[c] = 0;
        end
        e_key = '0; e_press = '0; e_rel = '0; e_rpt = '0;
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NK; c++) begin
            bit s;
            s = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = ~bus.din[c];
            e_press[c] = 0; e_rel[c] = 0; e_rpt[c] = 0;
            if (s != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DT + 1) begin
                    m_lvl[c] = s;
                    m_run[c] = 0;
                    if (s) e_press[c] = 1; else e_rel[c] = 1;
                    m_age[c] = 0; m_first[c] = 1;
                end
            end else begin
                if (m_lvl[c] && m_run[c] > 0) begin
                    m_age[c] = 0; m_first[c] = 1;
                end else if (m_lvl[c]) begin
                    m_age[c]++;
                    if (m_age[c] == (m_first[c] ? RD : RP)) begin
                        e_rpt[c] = 1; m_age[c] = 0; m_first[c] = 0;
                    end
                end
                m_run[c] = 0;
            end
            e_key[c] = m_lvl[c];
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " key_state"},     bus.key_state,     e_key);
        chk({tag, " press_pulse"},   bus.press_pulse,   e_press);
        chk({tag, " release_pulse"}, bus.release_pulse, e_rel);
        chk({tag, " repeat_pulse"},  bus.repeat_pulse,  e_rpt);
    endtask

    task automatic clear_rec();
        ecnt = 0;
        for (int c = 0; c < NK; c++) begin
            press_e[c] = -1; rel_e[c] = -1; rep_q[c].delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
        check_all("cycle");
        for (int c = 0; c < NK; c++) begin
            if (bus.press_pulse[c] === 1'b1 && press_e[c] < 0) press_e[c] = ecnt;
            if (bus.release_pulse[c] === 1'b1 && rel_e[c] < 0) rel_e[c] = ecnt;
            if (bus.repeat_pulse[c] === 1'b1) rep_q[c].push_back(ecnt);
        end
        ecnt++;
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(tag);
    endtask

    function automatic int first_rep(input int c, input int idx);
        return (rep_q[c].size() > idx) ? rep_q[c][idx] : -1;
    endfunction

    initial begin
        bus.din = '1;
        model_reset();
        clear_rec();
        #1 rst_n = 1'b0;
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();

        // single key press latency and pulse width
        clear_rec();
        bus.din[0] = 1'b0;
        repeat (6) step();
        chk("s1 no early press", press_e[0], -1);
        step();
        chk("s1 press edge", press_e[0], 6);
        chk("s1 key0 high", bus.key_state[0], 1);
        step();
        chk("s1 pulse width", bus.press_pulse[0], 0);
        chk("s1 other keys", bus.key_state[3:1], 0);
        bus.din[0] = 1'b1;
        repeat (8) step();

        // 4-sample glitch rejected, 5-sample press accepted
        clear_rec();
        bus.din[1] = 1'b0;
        repeat (4) step();
        bus.din[1] = 1'b1;
        repeat (8) step();
        chk("s2 glitch no press", press_e[1], -1);
        chk("s2 glitch key low", bus.key_state[1], 0);
        clear_rec();
        bus.din[1] = 1'b0;
        repeat (5) step();
        bus.din[1] = 1'b1;
        repeat (3) step();
        chk("s2 five samples press", press_e[1], 6);
        repeat (10) step();

        // auto-repeat and release
        clear_rec();
        bus.din[2] = 1'b0;
        for (int e = 0; e < 45; e++) begin
            if (e == 30) bus.din[2] = 1'b1;
            step();
        end
        chk("s3 repeat count", rep_q[2].size(), 4);
        chk("s3 repeat 1", first_rep(2, 0), 16);
        chk("s3 repeat 2", first_rep(2, 1), 21);
        chk("s3 repeat 3", first_rep(2, 2), 26);
        chk("s3 repeat 4", first_rep(2, 3), 31);
        chk("s3 release edge", rel_e[2], 36);
        chk("s3 key low", bus.key_state[2], 0);

        // release bounce while held restarts the repeat delay
        clear_rec();
        bus.din[1] = 1'b0;
        for (int e = 0; e < 30; e++) begin
            if (e == 8)  bus.din[1] = 1'b1;
            if (e == 11) bus.din[1] = 1'b0;
            step();
        end
        chk("s4 press edge", press_e[1], 6);
        chk("s4 no release", rel_e[1], -1);
        chk("s4 first repeat", first_rep(1, 0), 23);
        bus.din[1] = 1'b1;
        repeat (10) step();

        // simultaneous presses on two channels
        clear_rec();
        bus.din[0] = 1'b0;
        bus.din[3] = 1'b0;
        repeat (8) step();
        chk("s5 press ch0", press_e[0], 6);
        chk("s5 press ch3", press_e[3], 6);
        bus.din[0] = 1'b1;
        bus.din[3] = 1'b1;
        repeat (10) step();

        // reset during press debounce
        clear_rec();
        bus.din[0] = 1'b0;
        repeat (4) step();
        async_reset("s6 rst in debounce");
        bus.din[0] = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (15) step();
        chk("s6 no press after rst", press_e[0], -1);

        // reset during held
        clear_rec();
        bus.din[2] = 1'b0;
        repeat (12) step();
        chk("s6 held before rst", bus.key_state[2], 1);
        async_reset("s6 rst in held");
        chk("s6 key cleared", bus.key_state, 0);
        bus.din[2] = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        clear_rec();
        repeat (15) step();
        for (int c = 0; c < NK; c++) begin
            chk("s6 no press post rst", press_e[c], -1);
            chk("s6 no release post rst", rel_e[c], -1);
            chk("s6 no repeat post rst", rep_q[c].size(), 0);
        end

        // random bouncing on all keys
        begin
            int rate[NK];
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (cyc % 250 == 0)
                    for (int c = 0; c < NK; c++) rate[c] = $urandom_range(40, 2);
                for (int c = 0; c < NK; c++)
                    if ($urandom_range(rate[c] - 1) == 0) bus.din[c] = ~bus.din[c];
                if (cyc == 1500) begin
                    async_reset("rand rst");
                    repeat (2) step();
                    rst_n = 1'b1;
                end
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
